// File: rtl/div_seq_if.sv
// Purpose: EX-stage <-> divider handshake bundle.
//   master (EX):      drives signed_div_i, opdata1_i, opdata2_i, start_i, annul_i;
//                     observes result_o, ready_o, busy_o.
//   slave (divider):  the mirror image.
interface div_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_seq.sv
// Purpose: multi-cycle radix-2 restoring divider for DIV/DIVU.
//   clk, rst : clock and synchronous active-high reset
//   bus      : div_seq_if slave port
//     signed_div_i/opdata1_i/opdata2_i : op select, dividend, divisor (sampled at accept)
//     start_i/annul_i                  : level request held until ready_o / pipeline flush
//     result_o                         : {remainder, quotient}, valid while ready_o
//     busy_o                           : high while dividing or handling a zero divisor
// Latency: WIDTH step edges plus one finalize edge after the accept edge.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     rem;       // partial remainder, always < divisor magnitude
  logic [WIDTH-1:0]     dvd;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     dvs;       // divisor magnitude
  logic                 neg_q;
  logic                 neg_r;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  // Operand magnitudes; abs only applies to signed ops
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ?
                 WIDTH'(~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
  assign b_mag = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ?
                 WIDTH'(~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;

  // One restoring step: WIDTH+1 bits so the trial borrow shows up in the MSB
  logic [WIDTH:0] shifted, trial;
  assign shifted = {rem, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  // Sign fixup; -2^(W-1)/-1 simply wraps
  logic [WIDTH-1:0] q_fix, r_fix;
  assign q_fix = neg_q ? WIDTH'(~dvd + WIDTH'(1)) : dvd;
  assign r_fix = neg_r ? WIDTH'(~rem + WIDTH'(1)) : rem;

  // Control and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              dvd   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              cnt   <= '0;
              neg_q <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
              neg_r <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            end
          end
        end
        S_BYZERO: begin
          if (bus.annul_i) begin
            state <= S_FREE;
          end else begin
            state    <= S_END;
            result_q <= '0;
            ready_q  <= 1'b1;
          end
        end
        S_ON: begin
          if (bus.annul_i) begin
            state    <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
            cnt      <= '0;
          end else if (cnt == CNT_W'(WIDTH)) begin
            state    <= S_END;
            result_q <= {r_fix, q_fix};
            ready_q  <= 1'b1;
          end else begin
            rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_END: begin
          // Returning through FREE prevents back-to-back accept
          if (!bus.start_i || bus.annul_i) begin
            state    <= S_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = (state == S_ON) || (state == S_BYZERO);

endmodule

// File: tb/tb_div_seq.sv
// Purpose: directed self-checking bench for div_seq (WIDTH=32).
module tb_div_seq;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string        name;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] exp;
    int           lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept, scramble operands, wait for ready, hold extra cycles, then release
  task automatic run_op(input vec_t v, input int hold);
    int lat;
    logic [2*W-1:0] held;
    bus.signed_div_i = v.sgn;
    bus.opdata1_i    = v.a;
    bus.opdata2_i    = v.b;
    bus.start_i      = 1'b1;
    tick();
    bus.opdata1_i    = 32'hDEAD_BEEF;
    bus.opdata2_i    = 32'h0000_0003;
    bus.signed_div_i = ~v.sgn;
    chk({v.name, " busy_after_accept"}, 64'(bus.busy_o), 64'd1);
    lat = 0;
    while (!bus.ready_o && lat < 60) begin
      tick();
      lat++;
    end
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " result"}, bus.result_o, v.exp);
    chk({v.name, " busy_in_end"}, 64'(bus.busy_o), 64'd0);
    held = bus.result_o;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({v.name, " hold_ready"}, 64'(bus.ready_o), 64'd1);
      chk({v.name, " hold_result"}, bus.result_o, held);
    end
    bus.start_i = 1'b0;
    tick();
    chk({v.name, " release_ready"}, 64'(bus.ready_o), 64'd0);
    chk({v.name, " release_result"}, bus.result_o, 64'd0);
  endtask

  vec_t vecs[11];

  initial begin
    int rises;
    int lat;

    vecs[0]  = '{"divu_100_7",    1'b0, 32'd100,       32'd7,         {32'd2,         32'd14},        33};
    vecs[1]  = '{"div_m7_2",      1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF,  32'hFFFFFFFD},  33};
    vecs[2]  = '{"div_7_m2",      1'b1, 32'd7,         32'hFFFFFFFE,  {32'd1,         32'hFFFFFFFD},  33};
    vecs[3]  = '{"divu_by0",      1'b0, 32'd5,         32'd0,         64'd0,                          1};
    vecs[4]  = '{"div_by0",       1'b1, 32'hFFFFFFF9,  32'd0,         64'd0,                          1};
    vecs[5]  = '{"div_min_m1",    1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'd0,         32'h80000000},  33};
    vecs[6]  = '{"divu_min_max",  1'b0, 32'h80000000,  32'hFFFFFFFF,  {32'h80000000,  32'd0},         33};
    vecs[7]  = '{"divu_9_3",      1'b0, 32'd9,         32'd3,         {32'd0,         32'd3},         33};
    vecs[8]  = '{"divu_max_1",    1'b0, 32'hFFFFFFFF,  32'd1,         {32'd0,         32'hFFFFFFFF},  33};
    vecs[9]  = '{"div_m100_m7",   1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE,  32'd14},        33};
    vecs[10] = '{"divu_3_10",     1'b0, 32'd3,         32'd10,        {32'd3,         32'd0},         33};

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    tick();
    tick();
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_op(vecs[i], 0);

    // Annul mid-ON: no result, then a fresh op works normally
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    tick();
    repeat (9) tick();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    chk("annul_on_ready", 64'(bus.ready_o), 64'd0);
    chk("annul_on_busy", 64'(bus.busy_o), 64'd0);
    chk("annul_on_result", bus.result_o, 64'd0);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ready_o) rises++;
    end
    chk("annul_on_no_ready", 64'(rises), 64'd0);
    run_op(vecs[7], 0);

    // Start with annul in FREE is ignored
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    tick();
    chk("annul_free_busy", 64'(bus.busy_o), 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // Annul while handling a zero divisor
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b1;
    tick();
    chk("byzero_busy", 64'(bus.busy_o), 64'd1);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    chk("annul_byzero_ready", 64'(bus.ready_o), 64'd0);
    chk("annul_byzero_busy", 64'(bus.busy_o), 64'd0);

    // Annul in END drops ready even with start still held
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    tick();
    lat = 0;
    while (!bus.ready_o && lat < 60) begin
      tick();
      lat++;
    end
    chk("end_annul_reach", 64'(lat), 64'd33);
    bus.annul_i = 1'b1;
    tick();
    chk("end_annul_ready", 64'(bus.ready_o), 64'd0);
    chk("end_annul_result", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // Synchronous reset mid-ON, then an op held through END
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    tick();
    repeat (19) tick();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    tick();
    chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_on_result", bus.result_o, 64'd0);
    chk("rst_on_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b0;
    tick();
    run_op(vecs[0], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
